// File: rtl/wf_slot_allocator_pkg.sv
// Shared sizing constants and helpers for the wavefront slot allocator.
// A compute unit owns NUM_WF slots, each addressed by a WFID_W-bit wavefront id.
package wf_slot_allocator_pkg;

    localparam int NUM_WF        = 40;
    localparam int WFID_W        = 6;
    localparam int WF_FREE_CNT_W = 6;

    typedef logic [NUM_WF-1:0] wf_mask_t;
    typedef logic [WFID_W-1:0] wfid_t;

    // Ids at or above NUM_WF shift off the end and yield an empty mask.
    function automatic wf_mask_t wfid_onehot(input wfid_t wfid);
        return wf_mask_t'(1) << wfid;
    endfunction

endpackage

// File: rtl/prio_enc_40_to_6.sv
// Combinational priority encoder: returns the lowest set bit of free_mask.
// Bit 0 has the highest priority, so idx is 0 when no bit is set.
module prio_enc_40_to_6
    import wf_slot_allocator_pkg::*;
(
    input  logic [NUM_WF-1:0] free_mask,
    output logic [WFID_W-1:0] idx,
    output logic              any_free
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx      = '0;
        any_free = |free_mask;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                idx = WFID_W'(i);
            end
        end
    end

endmodule

// File: rtl/wf_slot_allocator.sv
// Allocates and releases per-compute-unit wavefront slots, and writes each new
// slot's initial value into the downstream per-wavefront register file.
module wf_slot_allocator
    import wf_slot_allocator_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req,
    input  logic [WIDTH-1:0]         alloc_data,
    output logic                     alloc_ready,
    output logic                     alloc_done,
    output logic [WFID_W-1:0]        alloc_wfid,
    input  logic                     release_en,
    input  logic [WFID_W-1:0]        release_wfid,
    output logic                     release_err,
    output logic                     wr_en,
    output logic [WFID_W-1:0]        wr_addr,
    output logic [WIDTH-1:0]         wr_data,
    output logic [NUM_WF-1:0]        busy_vec,
    output logic [WF_FREE_CNT_W-1:0] free_count
);

    logic [WFID_W-1:0] grant_idx;
    logic              any_free;
    logic              accept;
    logic              rel_ok;
    wf_mask_t          rel_mask;
    wf_mask_t          set_mask;
    wf_mask_t          clr_mask;

    prio_enc_40_to_6 u_prio_enc (
        .free_mask (~busy_vec),
        .idx       (grant_idx),
        .any_free  (any_free)
    );

    // Ready depends only on registered state, so requesters see no comb loop.
    assign alloc_ready = (free_count != '0);
    assign accept      = alloc_req && alloc_ready && any_free;

    assign rel_mask = wfid_onehot(release_wfid);
    assign rel_ok   = release_en && (|(busy_vec & rel_mask));
    assign set_mask = accept ? wfid_onehot(grant_idx) : '0;
    assign clr_mask = rel_ok ? rel_mask : '0;

    // Grant uses the pre-edge bitmap, so a slot freed this cycle is not reused
    // until the next one; simultaneous grant and release leave the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vec    <= '0;
            free_count  <= WF_FREE_CNT_W'(NUM_WF);
            alloc_done  <= 1'b0;
            alloc_wfid  <= '0;
            release_err <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            busy_vec    <= (busy_vec & ~clr_mask) | set_mask;
            alloc_done  <= accept;
            wr_en       <= accept;
            release_err <= release_en && !rel_ok;
            if (accept && !rel_ok) begin
                free_count <= free_count - WF_FREE_CNT_W'(1);
            end else if (rel_ok && !accept) begin
                free_count <= free_count + WF_FREE_CNT_W'(1);
            end
            if (accept) begin
                alloc_wfid <= grant_idx;
                wr_addr    <= grant_idx;
                wr_data    <= alloc_data;
            end
        end
    end

endmodule

// File: tb/tb_wf_slot_allocator.sv
// Scoreboard bench for wf_slot_allocator: a slot-array reference model predicts
// grants and release errors, and a negedge monitor checks every output cycle.
module tb_wf_slot_allocator;
    import wf_slot_allocator_pkg::*;

    localparam int W = 32;

    logic              clk;
    logic              rst;
    logic              alloc_req;
    logic [W-1:0]      alloc_data;
    logic              alloc_ready;
    logic              alloc_done;
    logic [5:0]        alloc_wfid;
    logic              release_en;
    logic [5:0]        release_wfid;
    logic              release_err;
    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [W-1:0]      wr_data;
    logic [39:0]       busy_vec;
    logic [5:0]        free_count;

    wf_slot_allocator #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_data   (alloc_data),
        .alloc_ready  (alloc_ready),
        .alloc_done   (alloc_done),
        .alloc_wfid   (alloc_wfid),
        .release_en   (release_en),
        .release_wfid (release_wfid),
        .release_err  (release_err),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy_vec     (busy_vec),
        .free_count   (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        int           wfid;
        logic [W-1:0] data;
    } exp_alloc_t;

    exp_alloc_t   aq[$];
    int           eq[$];
    bit           model_busy[40];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic [5:0]   last_addr = '0;
    logic [W-1:0] last_data = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: event at cycle %0d not predicted by the model", name, cyc);
    endtask

    function automatic int model_used();
        int n = 0;
        for (int i = 0; i < 40; i++) n += int'(model_busy[i]);
        return n;
    endfunction

    function automatic logic [39:0] model_vec();
        logic [39:0] v = '0;
        for (int i = 0; i < 40; i++) v[i] = model_busy[i];
        return v;
    endfunction

    // One clock of stimulus: predictions come from the pre-edge model state.
    task automatic apply_stimulus(input bit req, input logic [W-1:0] data, input bit ren, input int rid);
        bit acc;
        bit legal;
        int g;
        exp_alloc_t e;
        alloc_req    = req;
        alloc_data   = data;
        release_en   = ren;
        release_wfid = 6'(rid);
        acc   = req && (model_used() < 40);
        g     = -1;
        legal = ren && (rid < 40) && model_busy[rid];
        if (acc) begin
            for (int i = 39; i >= 0; i--) if (!model_busy[i]) g = i;
            e.cyc  = cyc + 1;
            e.wfid = g;
            e.data = data;
            aq.push_back(e);
        end
        if (ren && !legal) eq.push_back(cyc + 1);
        @(posedge clk);
        if (acc) model_busy[g] = 1'b1;
        if (legal) model_busy[rid] = 1'b0;
        #1;
        alloc_req  = 1'b0;
        release_en = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 40; i++) model_busy[i] = 1'b0;
        aq.delete();
        eq.delete();
        last_addr = '0;
        last_data = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_alloc_done"}, alloc_done, 1'b0);
        check_output({tag, "_wr_en"}, wr_en, 1'b0);
        check_output({tag, "_busy_vec"}, busy_vec, 40'h0);
        check_output({tag, "_free_count"}, free_count, 40);
        check_output({tag, "_wr_addr"}, wr_addr, 0);
        check_output({tag, "_wr_data"}, wr_data, 0);
        check_output({tag, "_alloc_wfid"}, alloc_wfid, 0);
        check_output({tag, "_release_err"}, release_err, 1'b0);
        check_output({tag, "_alloc_ready"}, alloc_ready, 1'b1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        clear_model();
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares registered outputs against the model between edges.
    always @(negedge clk) begin
        if (!rst) begin
            logic [39:0] mv;
            exp_alloc_t  e;
            mv = model_vec();
            check_output("busy_vec", busy_vec, mv);
            check_output("free_count", free_count, 40 - $countones(mv));
            check_output("invariant", free_count, 40 - $countones(busy_vec));
            check_output("alloc_ready", alloc_ready, $countones(mv) != 40);
            check_output("wr_en_vs_done", wr_en, alloc_done);
            if (alloc_done) begin
                if (aq.size() == 0) begin
                    report_fail("unexpected_alloc_done");
                end else begin
                    e = aq.pop_front();
                    check_output("alloc_latency", cyc, e.cyc);
                    check_output("alloc_wfid", alloc_wfid, e.wfid);
                    check_output("wr_addr", wr_addr, e.wfid);
                    check_output("wr_data", wr_data, e.data);
                    last_addr = 6'(e.wfid);
                    last_data = e.data;
                end
            end else begin
                if (aq.size() > 0 && aq[0].cyc <= cyc) begin
                    check_output("missing_alloc_done", alloc_done, 1'b1);
                    void'(aq.pop_front());
                end
                check_output("wr_addr_hold", wr_addr, last_addr);
                check_output("wr_data_hold", wr_data, last_data);
            end
            if (release_err) begin
                if (eq.size() == 0) report_fail("unexpected_release_err");
                else check_output("release_err_latency", cyc, eq.pop_front());
            end else if (eq.size() > 0 && eq[0] <= cyc) begin
                check_output("missing_release_err", release_err, 1'b1);
                void'(eq.pop_front());
            end
        end
    end

    initial begin
        rst          = 1'b1;
        alloc_req    = 1'b0;
        alloc_data   = '0;
        release_en   = 1'b0;
        release_wfid = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b0;

        // Fill all 40 slots in order.
        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, W'(100 + i), 1'b0, 0);
        #1;
        check_output("full_free_count", free_count, 0);
        check_output("full_alloc_ready", alloc_ready, 1'b0);

        // Requests while full are ignored.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, W'(900 + i), 1'b0, 0);
        check_output("full_busy_vec", busy_vec, {40{1'b1}});

        // Free slot 17 while full, then re-allocate it.
        apply_stimulus(1'b0, '0, 1'b1, 17);
        apply_stimulus(1'b1, W'(777), 1'b0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 0);
        check_output("refill_wfid", alloc_wfid, 17);
        check_output("refill_free_count", free_count, 0);

        // Busy {0..5}: same-cycle release 2 and alloc grants 6, then 2.
        pulse_reset();
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, W'(200 + i), 1'b0, 0);
        apply_stimulus(1'b1, W'(300), 1'b1, 2);
        check_output("simul_wfid", alloc_wfid, 6);
        check_output("simul_busy", busy_vec, 40'h7B);
        check_output("simul_free_count", free_count, 34);
        apply_stimulus(1'b1, W'(301), 1'b0, 0);
        check_output("reuse_wfid", alloc_wfid, 2);

        // Illegal releases: out of range, then an already-free slot.
        apply_stimulus(1'b0, '0, 1'b1, 45);
        apply_stimulus(1'b0, '0, 1'b1, 30);
        apply_stimulus(1'b0, '0, 1'b0, 0);

        // Reset while an alloc_done pulse is showing.
        apply_stimulus(1'b1, W'(400), 1'b0, 0);
        check_output("pre_reset_done", alloc_done, 1'b1);
        pulse_reset();
        apply_stimulus(1'b1, W'(555), 1'b0, 0);
        check_output("post_reset_wfid", alloc_wfid, 0);

        // Randomized traffic with occasional illegal release ids.
        for (int n = 0; n < 400; n++) begin
            apply_stimulus($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 9) < 4,
                           int'($urandom_range(0, 47)));
        end

        repeat (3) apply_stimulus(1'b0, '0, 1'b0, 0);
        check_output("alloc_queue_drained", aq.size(), 0);
        check_output("err_queue_drained", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
